// File: rtl/dma_controller.sv
`timescale 1ns/1ps
// Purpose : block DMA engine that copies 4-word blocks from an external device into memory at base+offset.
// Latency : BR one cycle after cmd_valid; LOAD one cycle after BG; each block takes 1 LOAD + (mem latency + 1) WRITE cycles.
// Backpressure: WRITE holds mem_write/mem_addr/mem_data until mem_ready; losing BG in LOAD/WRITE re-requests the bus and repeats the block.
//
// Ports:
//   clk, reset_n              - single clock, asynchronous active-low reset
//   cmd_valid/addr/length     - one-cycle CPU command (destination base, length in words)
//   BR / BG                   - bus request to / grant from the CPU
//   offset, ext_data          - word offset to the device and the 4-word block it returns
//   mem_write/addr/data/ready - memory write request and completion handshake
//   busy, dma_end_interrupt   - command in progress; one-cycle completion pulse
module dma_controller #(
    parameter int WORD_SIZE  = 16,
    parameter int BLOCK_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    input  logic [WORD_SIZE-1:0]  cmd_addr,
    input  logic [WORD_SIZE-1:0]  cmd_length,
    output logic                  BR,
    input  logic                  BG,
    output logic [WORD_SIZE-1:0]  offset,
    input  logic [BLOCK_SIZE-1:0] ext_data,
    output logic                  mem_write,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [BLOCK_SIZE-1:0] mem_data,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  dma_end_interrupt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [WORD_SIZE-1:0]    base_q;
    logic [WORD_SIZE-1:0]    blocks_q;
    logic [WORD_SIZE-1:0]    offset_q;
    logic [BLOCK_SIZE-1:0]   data_q;

    // ceil(len/4): whole blocks plus one more if any words are left over.
    // Done without a +3 pre-add so a length near 2^16 cannot overflow.
    logic [WORD_SIZE-1:0]    blocks_init;
    assign blocks_init = (cmd_length >> 2)
                       + {{(WORD_SIZE-1){1'b0}}, |cmd_length[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            blocks_q <= '0;
            offset_q <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        base_q   <= cmd_addr;
                        blocks_q <= blocks_init;
                        offset_q <= '0;
                        state_q  <= (blocks_init != '0) ? S_REQ : S_DONE;
                    end
                end
                S_REQ: begin
                    if (BG) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    // ext_data is only meaningful while the bus is granted
                    if (!BG) begin
                        state_q <= S_REQ;
                    end else begin
                        data_q  <= ext_data;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // A completion that coincides with grant loss still counts;
                    // only the choice of next state (LOAD vs REQ) depends on BG.
                    if (mem_ready) begin
                        if (blocks_q == {{(WORD_SIZE-1){1'b0}}, 1'b1}) begin
                            state_q <= S_DONE;
                        end else begin
                            offset_q <= offset_q + WORD_SIZE'(4);
                            blocks_q <= blocks_q - {{(WORD_SIZE-1){1'b0}}, 1'b1};
                            state_q  <= BG ? S_LOAD : S_REQ;
                        end
                    end else if (!BG) begin
                        state_q <= S_REQ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from state; the async reset of state_q drops BR at once.
    assign BR                = (state_q == S_REQ) || (state_q == S_LOAD) || (state_q == S_WRITE);
    assign busy              = (state_q != S_IDLE);
    assign dma_end_interrupt = (state_q == S_DONE);
    assign offset            = offset_q;
    assign mem_write         = (state_q == S_WRITE);
    assign mem_addr          = (state_q == S_WRITE) ? (base_q + offset_q) : '0;
    assign mem_data          = (state_q == S_WRITE) ? data_q : '0;

endmodule

// File: tb/tb_dma_controller.sv
`timescale 1ns/1ps
// Purpose : directed self-checking bench for dma_controller with bus-grant, device and memory responders.
// Latency : memory answers on the 4th WRITE cycle; grant follows BR by 2 cycles.
// Backpressure: grant can be forcibly withdrawn for a number of cycles to exercise grant loss.
module tb_dma_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_length = '0;
    logic        BR;
    logic        BG = 1'b0;
    logic [15:0] offset;
    logic [63:0] ext_data = '0;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [63:0] mem_data;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic        dma_end_interrupt;

    int tests_run    = 0;
    int tests_failed = 0;

    int br_cnt    = 0;
    int drop_cnt  = 0;
    int mem_cnt   = 0;
    int irq_count = 0;
    bit irq_prev  = 1'b0;
    bit irq_long  = 1'b0;
    bit br_seen   = 1'b0;
    logic [15:0] log_addr[$];
    logic [63:0] log_data[$];

    dma_controller #(.WORD_SIZE(16), .BLOCK_SIZE(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_length(cmd_length),
        .BR(BR), .BG(BG), .offset(offset), .ext_data(ext_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .busy(busy), .dma_end_interrupt(dma_end_interrupt)
    );

    always #5 clk = ~clk;

    // Device content: word k holds k*0x1111, so block at offset o is {w(o+3),w(o+2),w(o+1),w(o)}.
    function automatic logic [63:0] blk(input logic [15:0] o);
        logic [63:0] r;
        logic [15:0] k;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            k = o + 16'(i);
            r[16*i +: 16] = k * 16'h1111;
        end
        return r;
    endfunction

    // Bus grant + device responder
    initial forever begin
        @(negedge clk);
        if (drop_cnt > 0) begin
            BG = 1'b0;
            drop_cnt--;
        end else if (BR) begin
            if (br_cnt < 2) br_cnt++;
            BG = (br_cnt >= 2);
        end else begin
            br_cnt = 0;
            BG = 1'b0;
        end
        ext_data = BG ? blk(offset) : 64'h0;
    end

    // Memory responder: ready on the 4th cycle of a write; a completed write is logged
    initial forever begin
        @(negedge clk);
        if (mem_write) begin
            mem_cnt++;
            if (mem_cnt >= 4) begin
                mem_ready = 1'b1;
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_data);
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            mem_cnt = 0;
            mem_ready = 1'b0;
        end
    end

    // Interrupt / bus-request monitor
    initial forever begin
        @(negedge clk);
        if (dma_end_interrupt) irq_count++;
        if (dma_end_interrupt && irq_prev) irq_long = 1'b1;
        irq_prev = dma_end_interrupt;
        if (BR) br_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // Command accepted at the posedge; returns 1ns after it
    task automatic issue_cmd(input logic [15:0] a, input logic [15:0] l);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_length = l;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    // Returns in the interrupt cycle (1ns after a negedge) or with ok=0 after a cycle budget
    task automatic wait_done(output bit ok);
        int start;
        start = irq_count;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (irq_count != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++; if (BR !== 1'b0) begin tests_failed++; $display("FAIL reset_BR got %b want 0", BR); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (mem_write !== 1'b0 || mem_addr !== 16'h0 || mem_data !== 64'h0) begin
            tests_failed++; $display("FAIL reset_mem got wr=%b addr=%h data=%h want 0/0/0", mem_write, mem_addr, mem_data); end
        tests_run++; if (offset !== 16'h0 || dma_end_interrupt !== 1'b0) begin
            tests_failed++; $display("FAIL reset_offset_irq got off=%h irq=%b want 0/0", offset, dma_end_interrupt); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        bit ok;
        int irq0;
        clear_log();
        irq0 = irq_count;
        irq_long = 1'b0;
        issue_cmd(16'h01F4, 16'd12);
        tests_run++; if (BR !== 1'b1 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL nominal_br_timing got BR=%b busy=%b want 1/1", BR, busy); end
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL nominal_done got timeout want interrupt"); end
        tests_run++; if (BR !== 1'b0) begin tests_failed++; $display("FAIL nominal_br_in_done got %b want 0", BR); end
        tests_run++; if (log_addr.size() != 3) begin
            tests_failed++; $display("FAIL nominal_count got %0d want 3", log_addr.size()); end
        else begin
            tests_run++; if (log_addr[0] !== 16'h01F4 || log_data[0] !== 64'h3333_2222_1111_0000) begin
                tests_failed++; $display("FAIL nominal_w0 got %h/%h want 01f4/3333222211110000", log_addr[0], log_data[0]); end
            tests_run++; if (log_addr[1] !== 16'h01F8 || log_data[1] !== 64'h7777_6666_5555_4444) begin
                tests_failed++; $display("FAIL nominal_w1 got %h/%h want 01f8/7777666655554444", log_addr[1], log_data[1]); end
            tests_run++; if (log_addr[2] !== 16'h01FC || log_data[2] !== 64'hBBBB_AAAA_9999_8888) begin
                tests_failed++; $display("FAIL nominal_w2 got %h/%h want 01fc/bbbbaaaa99998888", log_addr[2], log_data[2]); end
        end
        @(posedge clk);
        #1;
        tests_run++; if (dma_end_interrupt !== 1'b0 || busy !== 1'b0 || BR !== 1'b0) begin
            tests_failed++; $display("FAIL nominal_idle got irq=%b busy=%b BR=%b want 0/0/0", dma_end_interrupt, busy, BR); end
        @(negedge clk);
        tests_run++; if (irq_count - irq0 != 1 || irq_long) begin
            tests_failed++; $display("FAIL nominal_irq_pulses got %0d long=%b want 1 long=0", irq_count - irq0, irq_long); end
    endtask

    task automatic test_zero_length();
        br_seen = 1'b0;
        issue_cmd(16'h1234, 16'd0);
        tests_run++; if (dma_end_interrupt !== 1'b1 || BR !== 1'b0) begin
            tests_failed++; $display("FAIL zero_irq got irq=%b BR=%b want 1/0", dma_end_interrupt, BR); end
        @(posedge clk);
        #1;
        tests_run++; if (dma_end_interrupt !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL zero_idle got irq=%b busy=%b want 0/0", dma_end_interrupt, busy); end
        @(negedge clk);
        tests_run++; if (br_seen) begin tests_failed++; $display("FAIL zero_br_seen got 1 want 0"); end
    endtask

    task automatic test_grant_loss();
        bit ok;
        bit hit;
        clear_log();
        issue_cmd(16'h01F4, 16'd12);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (log_addr.size() == 1 && mem_write) begin
                hit = 1'b1;
                break;
            end
        end
        tests_run++; if (!hit) begin tests_failed++; $display("FAIL gl_second_write got timeout want write"); end
        drop_cnt = 3;
        @(posedge clk);
        #1;
        tests_run++; if (mem_write !== 1'b0 || BR !== 1'b1) begin
            tests_failed++; $display("FAIL gl_drop got wr=%b BR=%b want 0/1", mem_write, BR); end
        tests_run++; if (offset !== 16'h0004) begin
            tests_failed++; $display("FAIL gl_offset_kept got %h want 0004", offset); end
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL gl_done got timeout want interrupt"); end
        tests_run++; if (log_addr.size() != 3) begin
            tests_failed++; $display("FAIL gl_count got %0d want 3", log_addr.size()); end
        else begin
            tests_run++; if (log_addr[1] !== 16'h01F8 || log_data[1] !== 64'h7777_6666_5555_4444) begin
                tests_failed++; $display("FAIL gl_rewrite got %h/%h want 01f8/7777666655554444", log_addr[1], log_data[1]); end
            tests_run++; if (log_addr[2] !== 16'h01FC || log_data[2] !== 64'hBBBB_AAAA_9999_8888) begin
                tests_failed++; $display("FAIL gl_w2 got %h/%h want 01fc/bbbbaaaa99998888", log_addr[2], log_data[2]); end
        end
        @(negedge clk);
    endtask

    task automatic test_busy_cmd_ignored();
        bit ok;
        clear_log();
        issue_cmd(16'h01F4, 16'd12);
        repeat (3) @(posedge clk);
        issue_cmd(16'h4000, 16'd40);
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL busy_done got timeout want interrupt"); end
        tests_run++; if (log_addr.size() != 3) begin
            tests_failed++; $display("FAIL busy_count got %0d want 3", log_addr.size()); end
        else begin
            tests_run++; if (log_addr[0] !== 16'h01F4 || log_addr[1] !== 16'h01F8 || log_addr[2] !== 16'h01FC) begin
                tests_failed++; $display("FAIL busy_addrs got %h %h %h want 01f4 01f8 01fc", log_addr[0], log_addr[1], log_addr[2]); end
        end
        @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_idle got %b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit hit;
        int irq0;
        clear_log();
        issue_cmd(16'h01F4, 16'd12);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (mem_write) begin
                hit = 1'b1;
                break;
            end
        end
        tests_run++; if (!hit) begin tests_failed++; $display("FAIL mr_write got timeout want write"); end
        irq0 = irq_count;
        #1;
        reset_n = 1'b0;
        #1;
        tests_run++; if (BR !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0 || dma_end_interrupt !== 1'b0) begin
            tests_failed++; $display("FAIL mr_outputs got BR=%b wr=%b busy=%b irq=%b want 0000", BR, mem_write, busy, dma_end_interrupt); end
        tests_run++; if (mem_addr !== 16'h0 || mem_data !== 64'h0 || offset !== 16'h0) begin
            tests_failed++; $display("FAIL mr_buses got addr=%h data=%h off=%h want 0", mem_addr, mem_data, offset); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++; if (irq_count != irq0 || log_addr.size() != 0) begin
            tests_failed++; $display("FAIL mr_no_irq got irq=%0d writes=%0d want %0d/0", irq_count, log_addr.size(), irq0); end
        issue_cmd(16'h0100, 16'd4);
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL mr_after_done got timeout want interrupt"); end
        tests_run++; if (log_addr.size() != 1) begin
            tests_failed++; $display("FAIL mr_after_count got %0d want 1", log_addr.size()); end
        else begin
            tests_run++; if (log_addr[0] !== 16'h0100 || log_data[0] !== 64'h3333_2222_1111_0000) begin
                tests_failed++; $display("FAIL mr_after_w0 got %h/%h want 0100/3333222211110000", log_addr[0], log_data[0]); end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_round();
        bit ok;
        clear_log();
        issue_cmd(16'hFFFC, 16'd5);
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL wrap_done got timeout want interrupt"); end
        tests_run++; if (log_addr.size() != 2) begin
            tests_failed++; $display("FAIL wrap_count got %0d want 2", log_addr.size()); end
        else begin
            tests_run++; if (log_addr[0] !== 16'hFFFC || log_data[0] !== 64'h3333_2222_1111_0000) begin
                tests_failed++; $display("FAIL wrap_w0 got %h/%h want fffc/3333222211110000", log_addr[0], log_data[0]); end
            tests_run++; if (log_addr[1] !== 16'h0000 || log_data[1] !== 64'h7777_6666_5555_4444) begin
                tests_failed++; $display("FAIL wrap_w1 got %h/%h want 0000/7777666655554444", log_addr[1], log_data[1]); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_length();
        test_grant_loss();
        test_busy_cmd_ignored();
        test_mid_reset();
        test_wrap_round();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
